// File: rtl/buf_addr_pool.sv
// Multi-channel buffer-address free list: FIFO recycling of fixed-size buffers
// with per-channel quota, ownership tracking and rejection of bad frees.
module buf_addr_pool #(
   parameter int                         BUFF_ADDR_WIDTH = 32,
   parameter int                         POOL_DEPTH      = 32,
   parameter int                         NUM_CHANNELS    = 4,
   parameter int                         CH_QUOTA        = 16,
   parameter logic [BUFF_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
   parameter int                         STRIDE_LOG2     = 6,
   localparam int IDX_W = $clog2(POOL_DEPTH),
   localparam int CNT_W = IDX_W + 1,
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic                          init_done,
   input  logic                          alloc_req,
   input  logic [CH_W-1:0]               alloc_ch,
   output logic                          alloc_ready,
   output logic                          alloc_valid,
   output logic [BUFF_ADDR_WIDTH-1:0]    alloc_addr,
   output logic [CH_W-1:0]               alloc_ch_out,
   input  logic                          free_req,
   input  logic [CH_W-1:0]               free_ch,
   input  logic [BUFF_ADDR_WIDTH-1:0]    free_addr,
   output logic                          free_err,
   output logic [CNT_W-1:0]              free_count,
   output logic [NUM_CHANNELS*CNT_W-1:0] ch_count
);

   localparam logic [BUFF_ADDR_WIDTH-1:0] ALIGN_MASK =
      BUFF_ADDR_WIDTH'((64'd1 << STRIDE_LOG2) - 64'd1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        head, tail;
   logic [CNT_W-1:0]        ch_cnt   [NUM_CHANNELS];
   logic [POOL_DEPTH-1:0]   owned;
   logic [CH_W-1:0]         owner    [POOL_DEPTH];
   logic [IDX_W-1:0]        fl_mem   [POOL_DEPTH];

   logic                    alloc_fire;
   logic [IDX_W-1:0]        head_idx;
   logic [CNT_W-1:0]        sel_cnt;
   logic                    ch_ok;
   logic [BUFF_ADDR_WIDTH-1:0] off, full_idx;
   logic [IDX_W-1:0]        free_idx;
   logic                    free_ok;
   logic [NUM_CHANNELS-1:0] ch_inc, ch_dec;

   // Init fills the free list with indices 0..POOL_DEPTH-1; tail doubles as the index.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (tail == IDX_W'(POOL_DEPTH - 1)) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   assign init_done = (state == ST_RUN);
   assign head_idx  = fl_mem[head];

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      sel_cnt = '0;
      ch_ok   = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (alloc_ch == CH_W'(c)) begin
            sel_cnt = ch_cnt[c];
            ch_ok   = 1'b1;
         end
      end
   end

   assign alloc_ready = (state == ST_RUN) && (free_count != '0) &&
                        (sel_cnt < CNT_W'(CH_QUOTA)) && ch_ok;
   assign alloc_fire  = alloc_req && alloc_ready;

   // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range check.
   assign off      = free_addr - BASE_ADDR;
   assign full_idx = off >> STRIDE_LOG2;
   assign free_idx = full_idx[IDX_W-1:0];
   assign free_ok  = free_req && (state == ST_RUN) &&
                     ((off & ALIGN_MASK) == '0) &&
                     (full_idx < BUFF_ADDR_WIDTH'(POOL_DEPTH)) &&
                     owned[free_idx] && (owner[free_idx] == free_ch);

   always_comb begin
      ch_inc = '0;
      ch_dec = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         ch_inc[c] = alloc_fire && (alloc_ch == CH_W'(c));
         ch_dec[c] = free_ok && (free_ch == CH_W'(c));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_INIT;
         head         <= '0;
         tail         <= '0;
         free_count   <= '0;
         owned        <= '0;
         alloc_valid  <= 1'b0;
         alloc_addr   <= '0;
         alloc_ch_out <= '0;
         free_err     <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++) ch_cnt[c] <= '0;
      end else begin
         state       <= state_nxt;
         alloc_valid <= alloc_fire;
         free_err    <= free_req && !free_ok;
         if (state == ST_INIT) begin
            tail       <= tail + 1'b1;
            free_count <= free_count + 1'b1;
         end else begin
            free_count <= free_count + CNT_W'(free_ok) - CNT_W'(alloc_fire);
            if (free_ok) tail <= tail + 1'b1;
            if (alloc_fire) head <= head + 1'b1;
         end
         if (alloc_fire) begin
            owned[head_idx] <= 1'b1;
            alloc_addr      <= BASE_ADDR + (BUFF_ADDR_WIDTH'(head_idx) << STRIDE_LOG2);
            alloc_ch_out    <= alloc_ch;
         end
         // A same-cycle free never targets head_idx: that buffer is not yet owned.
         if (free_ok) owned[free_idx] <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++)
            ch_cnt[c] <= ch_cnt[c] + CNT_W'(ch_inc[c]) - CNT_W'(ch_dec[c]);
      end
   end

   // NOTE: storage arrays carry no reset; init rewrites the free list and owned gates owner.
   always_ff @(posedge clk) begin
      if (state == ST_INIT)  fl_mem[tail] <= tail;
      else if (free_ok)      fl_mem[tail] <= free_idx;
      if (alloc_fire)        owner[head_idx] <= alloc_ch;
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch_count
      assign ch_count[g*CNT_W +: CNT_W] = ch_cnt[g];
   end

endmodule

// File: tb/tb_buf_addr_pool.sv
// Directed bench for buf_addr_pool: a per-cycle vector table plus a
// hand-written mid-run reset sequence.
module tb_buf_addr_pool;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic        alloc_req;
   logic [0:0]  alloc_ch;
   logic        alloc_ready;
   logic        alloc_valid;
   logic [31:0] alloc_addr;
   logic [0:0]  alloc_ch_out;
   logic        free_req;
   logic [0:0]  free_ch;
   logic [31:0] free_addr;
   logic        free_err;
   logic [3:0]  free_count;
   logic [7:0]  ch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   buf_addr_pool #(
      .BUFF_ADDR_WIDTH(32), .POOL_DEPTH(8), .NUM_CHANNELS(2), .CH_QUOTA(6),
      .BASE_ADDR(32'h1000), .STRIDE_LOG2(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .alloc_req(alloc_req), .alloc_ch(alloc_ch), .alloc_ready(alloc_ready),
      .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ch_out(alloc_ch_out),
      .free_req(free_req), .free_ch(free_ch), .free_addr(free_addr),
      .free_err(free_err), .free_count(free_count), .ch_count(ch_count)
   );

   typedef struct {
      logic        areq;
      logic        ach;
      logic        freq;
      logic        fch;
      logic [31:0] faddr;
      logic        rdy;
      logic        vld;
      logic [31:0] addr;
      logic        acho;
      logic        err;
      int          fc;
      int          c0;
      int          c1;
      logic        done;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic areq, input logic ach, input logic freq, input logic fch,
                      input logic [31:0] faddr, input logic rdy, input logic vld,
                      input logic [31:0] addr, input logic acho, input logic err,
                      input int fc, input int c0, input int c1, input logic done);
      vec_t v;
      v.areq = areq; v.ach = ach; v.freq = freq; v.fch = fch; v.faddr = faddr;
      v.rdy = rdy; v.vld = vld; v.addr = addr; v.acho = acho; v.err = err;
      v.fc = fc; v.c0 = c0; v.c1 = c1; v.done = done;
      vecs.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0; alloc_req = 1'b0; alloc_ch = '0;
      free_req = 1'b0; free_ch = '0; free_addr = '0;

      // areq ach freq fch faddr | rdy vld addr acho err fc c0 c1 done
      // Init: alloc held high, ready stays low; a free during init is rejected.
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 1,0,0,0);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 2,0,0,0);
      add(1,0, 1,0,32'h1000, 0,0,32'h0,   0,1, 3,0,0,0);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 4,0,0,0);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 5,0,0,0);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 6,0,0,0);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 7,0,0,0);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 8,0,0,1);
      // Channel 0 up to quota, then channel 1 exhausts the pool.
      add(1,0, 0,0,32'h0,    1,1,32'h1000,0,0, 7,1,0,1);
      add(1,0, 0,0,32'h0,    1,1,32'h1040,0,0, 6,2,0,1);
      add(1,0, 0,0,32'h0,    1,1,32'h1080,0,0, 5,3,0,1);
      add(1,0, 0,0,32'h0,    1,1,32'h10C0,0,0, 4,4,0,1);
      add(1,0, 0,0,32'h0,    1,1,32'h1100,0,0, 3,5,0,1);
      add(1,0, 0,0,32'h0,    1,1,32'h1140,0,0, 2,6,0,1);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 2,6,0,1);
      add(1,1, 0,0,32'h0,    1,1,32'h1180,1,0, 1,6,1,1);
      add(1,1, 0,0,32'h0,    1,1,32'h11C0,1,0, 0,6,2,1);
      add(1,1, 0,0,32'h0,    0,0,32'h0,   0,0, 0,6,2,1);
      add(1,0, 0,0,32'h0,    0,0,32'h0,   0,0, 0,6,2,1);
      // FIFO reuse: freed order 0x1080, 0x1000 comes back in that order.
      add(0,0, 1,0,32'h1080, 0,0,32'h0,   0,0, 1,5,2,1);
      add(0,1, 1,0,32'h1000, 1,0,32'h0,   0,0, 2,4,2,1);
      add(1,1, 0,0,32'h0,    1,1,32'h1080,1,0, 1,4,3,1);
      add(1,1, 0,0,32'h0,    1,1,32'h1000,1,0, 0,4,4,1);
      // Free errors: double free, misaligned, out of range, below base, wrong channel.
      add(0,0, 1,0,32'h1040, 0,0,32'h0,   0,0, 1,3,4,1);
      add(0,0, 1,0,32'h1040, 1,0,32'h0,   0,1, 1,3,4,1);
      add(0,0, 1,0,32'h1044, 1,0,32'h0,   0,1, 1,3,4,1);
      add(0,0, 1,0,32'h1200, 1,0,32'h0,   0,1, 1,3,4,1);
      add(0,0, 1,0,32'h0FC0, 1,0,32'h0,   0,1, 1,3,4,1);
      add(0,0, 1,1,32'h10C0, 1,0,32'h0,   0,1, 1,3,4,1);
      // Simultaneous alloc ch1 + valid free ch0 with one buffer left.
      add(1,1, 1,0,32'h10C0, 1,1,32'h1040,1,0, 1,2,5,1);
      add(1,1, 0,0,32'h0,    1,1,32'h10C0,1,0, 0,2,6,1);
      // No bypass when empty; freeing the buffer being granted is rejected.
      add(1,0, 1,1,32'h1180, 0,0,32'h0,   0,0, 1,2,5,1);
      add(1,0, 1,0,32'h1180, 1,1,32'h1180,0,1, 0,3,5,1);
      // Return three buffers so five remain held.
      add(0,0, 1,1,32'h11C0, 0,0,32'h0,   0,0, 1,3,4,1);
      add(0,0, 1,1,32'h1080, 1,0,32'h0,   0,0, 2,3,3,1);
      add(0,0, 1,1,32'h1000, 1,0,32'h0,   0,0, 3,3,2,1);

      repeat (2) @(posedge clk);
      #1;
      check("rst init_done", 32'(init_done), 32'd0);
      check("rst alloc_valid", 32'(alloc_valid), 32'd0);
      check("rst free_count", 32'(free_count), 32'd0);
      check("rst ch_count", 32'(ch_count), 32'd0);
      check("rst free_err", 32'(free_err), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         alloc_req = vecs[i].areq; alloc_ch  = vecs[i].ach;
         free_req  = vecs[i].freq; free_ch   = vecs[i].fch; free_addr = vecs[i].faddr;
         #1;
         check($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d alloc_valid", i), 32'(alloc_valid), 32'(vecs[i].vld));
         if (vecs[i].vld) begin
            check($sformatf("v%0d alloc_addr", i), alloc_addr, vecs[i].addr);
            check($sformatf("v%0d alloc_ch_out", i), 32'(alloc_ch_out), 32'(vecs[i].acho));
         end
         check($sformatf("v%0d free_err", i), 32'(free_err), 32'(vecs[i].err));
         check($sformatf("v%0d free_count", i), 32'(free_count), 32'(vecs[i].fc));
         check($sformatf("v%0d ch_count0", i), 32'(ch_count[3:0]), 32'(vecs[i].c0));
         check($sformatf("v%0d ch_count1", i), 32'(ch_count[7:4]), 32'(vecs[i].c1));
         check($sformatf("v%0d init_done", i), 32'(init_done), 32'(vecs[i].done));
      end

      // Mid-run reset with five buffers held and a grant on the outputs.
      alloc_req = 1'b1; alloc_ch = 1'b0; free_req = 1'b0;
      @(posedge clk);
      #1;
      check("pre-rst alloc_valid", 32'(alloc_valid), 32'd1);
      check("pre-rst alloc_addr", alloc_addr, 32'h11C0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-rst alloc_valid", 32'(alloc_valid), 32'd0);
      check("mid-rst alloc_addr", alloc_addr, 32'd0);
      check("mid-rst free_count", 32'(free_count), 32'd0);
      check("mid-rst ch_count", 32'(ch_count), 32'd0);
      check("mid-rst init_done", 32'(init_done), 32'd0);
      check("mid-rst alloc_ready", 32'(alloc_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         #1;
         check($sformatf("reinit%0d alloc_ready", k), 32'(alloc_ready), 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("reinit%0d free_count", k), 32'(free_count), 32'(k));
         check($sformatf("reinit%0d init_done", k), 32'(init_done), (k == 8) ? 32'd1 : 32'd0);
      end
      check("reinit ch_count", 32'(ch_count), 32'd0);
      #1;
      check("regrant0 alloc_ready", 32'(alloc_ready), 32'd1);
      @(posedge clk);
      #1;
      check("regrant0 alloc_valid", 32'(alloc_valid), 32'd1);
      check("regrant0 alloc_addr", alloc_addr, 32'h1000);
      @(posedge clk);
      #1;
      check("regrant1 alloc_addr", alloc_addr, 32'h1040);
      check("regrant1 ch_count0", 32'(ch_count[3:0]), 32'd2);
      alloc_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/buf_addr_pool.md
Name: buf_addr_pool

Overview:
- Parametrised, multi-channel buffer-address manager: a free list of fixed-size buffer addresses with per-channel quota, ownership tracking and free-error detection.
- Successor to the single-channel address buffer that sits between the packet datapath and the bbq scheduler.
- Produces buffer addresses for enqueue, reclaims them on dequeue, and self-initialises after reset.

Parameters:
- BUFF_ADDR_WIDTH, 32, width of buffer addresses.
- POOL_DEPTH, 32, number of buffers managed; power of two, >=2.
- NUM_CHANNELS, 4, number of requesting channels; >=1.
- CH_QUOTA, 16, maximum buffers held simultaneously per channel; 1..POOL_DEPTH.
- BASE_ADDR, 0, address of buffer index 0.
- STRIDE_LOG2, 6, log2 of buffer size in address units.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- init_done  out  1  pool initialised and operational.
- alloc_req  in  1  allocation request.
- alloc_ch  in  max(1,clog2(NUM_CHANNELS))  requesting channel.
- alloc_ready  out  1  request can be accepted this cycle (combinational).
- alloc_valid  out  1  one-cycle grant pulse.
- alloc_addr  out  BUFF_ADDR_WIDTH  granted address.
- alloc_ch_out  out  same as alloc_ch  channel of the grant.
- free_req  in  1  return request; never back-pressured.
- free_ch  in  same as alloc_ch  returning channel.
- free_addr  in  BUFF_ADDR_WIDTH  returned address.
- free_err  out  1  one-cycle pulse: previous cycle's free was rejected.
- free_count  out  clog2(POOL_DEPTH)+1  buffers currently in the free list.
- ch_count  out  NUM_CHANNELS*(clog2(POOL_DEPTH)+1)  flattened per-channel held counts; channel 0 in the LSBs.

Behaviour:
- Reset, asserted asynchronously:
  - all outputs 0; head, tail and free_count cleared; every ch_count 0; all owned bits cleared; FSM enters INIT.
  - Reset mid-operation discards all outstanding allocations.
- FSM INIT:
  - For POOL_DEPTH cycles, writes indices 0,1,...,POOL_DEPTH-1 to the free-list RAM at the tail; free_count increments each cycle.
  - Moves to RUN after the last write. init_done goes to 1 on the cycle free_count reaches POOL_DEPTH and stays 1 until reset.
- INIT restrictions: alloc_ready=0; any free_req is rejected with free_err.
- Address mapping:
  - addr = BASE_ADDR + (index << STRIDE_LOG2), truncated to BUFF_ADDR_WIDTH.
  - Reverse: off = free_addr - BASE_ADDR; index = off >> STRIDE_LOG2.
- alloc_ready = RUN && free_count!=0 && ch_count[alloc_ch] < CH_QUOTA && alloc_ch < NUM_CHANNELS.
- Accept on alloc_req && alloc_ready:
  - pop the head index; set owned[index]=1 and owner[index]=alloc_ch; increment ch_count[alloc_ch] and decrement free_count.
  - Next cycle: alloc_valid=1, alloc_addr, alloc_ch_out. Latency is 1 cycle; one grant per cycle maximum.
- Grant order is FIFO: after init, grants are index 0,1,2,..., then returned buffers in the order they were freed.
- Free validity: free_req in RUN is accepted only if all of the following hold:
  - off's low STRIDE_LOG2 bits are 0;
  - index < POOL_DEPTH (unsigned, so addresses below BASE_ADDR fail);
  - owned[index]=1;
  - owner[index]==free_ch.
- Accepted free: push the index at the tail; clear owned; decrement ch_count[free_ch]; increment free_count.
- Rejected free: no state change; free_err=1 next cycle. This covers double-free, misaligned, out-of-range, wrong channel, and any free during INIT.
- Same-cycle alloc and free:
  - Both are processed; free_count net unchanged.
  - There is no bypass: if free_count==0, alloc_ready stays 0 even while a free is in flight.
  - Quota is evaluated on registered ch_count, so a same-channel free does not raise alloc_ready in the same cycle.
- Freeing the address being allocated in the same cycle is rejected, because owned is still 0.
- Pointers wrap modulo POOL_DEPTH.
- free_count can never exceed POOL_DEPTH, since double-free is rejected.

Test Plan:
- Bench config: POOL_DEPTH=8, NUM_CHANNELS=2, CH_QUOTA=6, BASE_ADDR=0x1000, STRIDE_LOG2=6.
- Init: release reset, hold alloc_req=1 -> alloc_ready=0 for 8 cycles, free_count counts 1..8, init_done=1 at count 8; first grant alloc_addr=0x1000, second 0x1040.
- Quota/exhaust: ch0 requests continuously -> grants 0x1000..0x1140 (6 grants), then alloc_ready=0 while ch_count0=6. ch1 then gets 0x1180 and 0x11C0; free_count=0 and alloc_ready=0 for both channels.
- FIFO reuse: full pool; ch0 frees 0x1080, then 0x1000 -> free_count=2, ch_count0=4; the next two ch1 grants are 0x1080 then 0x1000.
- Errors: free 0x1040 twice (second -> free_err); free 0x1044 (misaligned); 0x1200 (out of range); 0x0FC0 (below base); ch1 freeing a ch0 buffer -> free_err each time, counts unchanged.
- Simultaneous: free_count=1, alloc ch1 and a valid free ch0 in the same cycle -> grant issued, free accepted, free_count stays 1; next grant is the freed address.
- Reset mid-run: assert rst_n=0 with 5 buffers held -> outputs 0 immediately; after release, re-init takes 8 cycles, then grants restart at 0x1000 and all ch_count=0.
